// File: rtl/wb_ifetch.sv
// Instruction fetch unit: single-outstanding Wishbone classic read master feeding a prefetch FIFO.
// Define IFETCH_TIMEOUT_EN to enable the bus watchdog that sets a sticky fetch_err_o.
module wb_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        fetch_err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   adr_q, adr_d;
  logic          stb_q, stb_d;
  logic          err_q, err_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc [DEPTH];
  logic          push, pop, timeout;

`ifdef IFETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr_q, tmr_d;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stb_d      = stb_q;
    err_d      = err_q;
    push       = 1'b0;
    timeout    = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
    tmr_d = tmr_q;
    if (state_q != S_IDLE && !wb_ack_i) begin
      if (tmr_q == '0) timeout = 1'b1;
      else tmr_d = tmr_q - 1'b1;
    end
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!redirect_i && count_q < CW'(DEPTH) && !err_q) begin
          stb_d   = 1'b1;
          state_d = S_REQ;
`ifdef IFETCH_TIMEOUT_EN
          tmr_d = TW'(TIMEOUT - 1);
`endif
        end
      end
      S_REQ: begin
        if (wb_ack_i) begin
          stb_d   = 1'b0;
          state_d = S_IDLE;
          if (!redirect_i) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (redirect_i) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (wb_ack_i) begin
          stb_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        stb_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    if (timeout) begin
      stb_d   = 1'b0;
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      err_d      = 1'b0;
    end
  end

  // An abandoned read keeps presenting its original address until the slave acks.
  assign adr_d = (state_d == S_DISCARD) ? adr_q : fetch_pc_d;

  assign pop = (count_q != '0) && instr_ready_i && !redirect_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (redirect_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      adr_q      <= {RESET_PC[31:2], 2'b00};
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      adr_q      <= adr_d;
      stb_q      <= stb_d;
      err_q      <= err_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr_q <= '0;
    else tmr_q <= tmr_d;
  end
  assign fetch_err_o = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign fetch_err_o    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr_q] <= wb_dat_i;
      fifo_pc[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  assign instr_valid_o = (count_q != '0);
  assign instr_o       = fifo_instr[rd_ptr_q];
  assign instr_pc_o    = fifo_pc[rd_ptr_q];
  assign wb_adr_o      = {adr_q[31:2], 2'b00};
  assign wb_stb_o      = stb_q;
  assign wb_cyc_o      = stb_q;
  assign wb_dat_o      = 32'd0;
  assign wb_we_o       = 1'b0;
  assign wb_sel_o      = 4'hF;
endmodule

// File: tb/tb_wb_ifetch.sv
// Bench for wb_ifetch: latency-programmable Wishbone slave, instruction-stream scoreboard,
// a table of redirect/consume scenarios and hand-written multi-cycle corner cases.
module tb_wb_ifetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o, instr_pc_o;
  logic        fetch_err_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o, wb_cyc_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;

  wb_ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
    .instr_pc_o(instr_pc_o), .fetch_err_o(fetch_err_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Slave: registered ack after sl_lat extra cycles, data = sl_base + word index.
  int          sl_lat = 0;
  logic [31:0] sl_base = 32'd0;
  logic        sl_mute = 1'b0;
  int          sl_wcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_i <= 1'b0;
      wb_dat_i <= 32'd0;
      sl_wcnt  <= 0;
    end else if (wb_stb_o && !wb_ack_i && !sl_mute) begin
      if (sl_wcnt >= sl_lat) begin
        wb_ack_i <= 1'b1;
        wb_dat_i <= sl_base + (wb_adr_o >> 2);
        sl_wcnt  <= 0;
      end else begin
        sl_wcnt <= sl_wcnt + 1;
      end
    end else begin
      wb_ack_i <= 1'b0;
      if (!wb_stb_o) sl_wcnt <= 0;
    end
  end

  logic        prev_stb, prev_ack;
  logic [31:0] prev_adr;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stb <= 1'b0;
      prev_ack <= 1'b0;
    end else begin
      check("stb_eq_cyc", {31'd0, wb_cyc_o}, {31'd0, wb_stb_o});
      if (prev_stb && prev_ack) check("idle_gap", {31'd0, wb_stb_o}, 32'd0);
      if (prev_stb && !prev_ack && wb_stb_o) check("adr_stable", wb_adr_o, prev_adr);
      prev_stb <= wb_stb_o;
      prev_ack <= wb_ack_i;
      prev_adr <= wb_adr_o;
    end
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t sb[$];

  task automatic sb_push(input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = sl_base + (pc >> 2);
    sb.push_back(e);
  endtask

  task automatic expect_stream(input logic [31:0] pc0, input int n);
    logic [31:0] pc = pc0;
    sb.delete();
    for (int i = 0; i < n; i++) begin
      sb_push(pc);
      pc = pc + 32'd4;
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: ready every third cycle
  task automatic consume(input int n, input int mode, input string tag);
    int got = 0;
    int cyc = 0;
    exp_t e;
    while (got < n && cyc < 2000) begin
      case (mode)
        0: instr_ready_i = 1'b1;
        1: instr_ready_i = 1'($urandom_range(0, 1));
        default: instr_ready_i = (cyc % 3 == 0);
      endcase
      if (instr_valid_o && instr_ready_i) begin
        e = sb.pop_front();
        check({tag, "_pc"}, instr_pc_o, e.pc);
        check({tag, "_instr"}, instr_o, e.ins);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    instr_ready_i = 1'b0;
    check({tag, "_count"}, got, n);
  endtask

  task automatic wait_stb(input int budget, input string tag);
    int w = 0;
    while (!wb_stb_o && w < budget) begin
      @(negedge clk);
      w++;
    end
    check(tag, {31'd0, wb_stb_o}, 32'd1);
  endtask

  task automatic wait_ack(input int budget, input string tag);
    int w = 0;
    while (!wb_ack_i && w < budget) begin
      @(negedge clk);
      w++;
    end
    check(tag, {31'd0, wb_ack_i}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    instr_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("rst_err", {31'd0, fetch_err_o}, 32'd0);
    check("rst_adr", wb_adr_o, 32'h0000_0000);
    check("tie_we", {31'd0, wb_we_o}, 32'd0);
    check("tie_sel", {28'd0, wb_sel_o}, 32'hF);
    check("tie_dat", wb_dat_o, 32'd0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] target;
    int          lat;
    logic [31:0] base;
    int          n;
    int          mode;
    logic [31:0] exp_first_pc;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int   acks, cyc, bad, hi, rise1, rise2, vfirst;
    logic pstb;
    exp_t e;

    vecs[0] = '{32'h0000_0200, 0, 32'h0000_1000, 6, 0, 32'h0000_0200};
    vecs[1] = '{32'h0000_0333, 2, 32'h2000_0000, 5, 1, 32'h0000_0330};
    vecs[2] = '{32'hFFFF_FFF8, 1, 32'h0000_0055, 5, 0, 32'hFFFF_FFF8};
    vecs[3] = '{32'h0000_1001, 4, 32'hABCD_0000, 4, 1, 32'h0000_1000};
    vecs[4] = '{32'h0000_0010, 0, 32'h0000_0000, 3, 2, 32'h0000_0010};

    // slow first fetch
    sl_lat = 65; sl_base = 32'h13; sl_mute = 1'b0;
    do_reset();
    expect_stream(32'h0, 1);
    wait_stb(5, "t1_stb");
    check("t1_adr0", wb_adr_o, 32'h0);
    consume(1, 0, "t1");
    wait_stb(5, "t1_stb2");
    check("t1_adr4", wb_adr_o, 32'h4);

    // latency, throughput, then full FIFO
    sl_lat = 0; sl_base = 32'd1;
    do_reset();
    expect_stream(32'h0, 4);
    rise1 = -1; rise2 = -1; vfirst = -1; pstb = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wb_stb_o && !pstb) begin
        if (rise1 < 0) rise1 = i;
        else if (rise2 < 0) rise2 = i;
      end
      if (instr_valid_o && vfirst < 0) vfirst = i;
      pstb = wb_stb_o;
      @(negedge clk);
    end
    check("lat_first_valid", vfirst - rise1, 2);
    check("lat_stb_spacing", rise2 - rise1, 3);
    bad = 0;
    repeat (8) begin
      if (wb_stb_o) bad++;
      @(negedge clk);
    end
    check("full_no_req", bad, 0);
    check("full_valid", {31'd0, instr_valid_o}, 32'd1);
    consume(1, 0, "full_pop");
    wait_stb(5, "full_refill_stb");
    check("full_refill_adr", wb_adr_o, 32'h10);
    sb_push(32'h10);
    consume(4, 0, "full_drain");

    // redirect while read of 0x8 is outstanding
    sl_lat = 20; sl_base = 32'h100;
    do_reset();
    expect_stream(32'h0, 2);
    consume(2, 0, "t3_pre");
    cyc = 0;
    while (!(wb_stb_o && wb_adr_o == 32'h8) && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("t3_req8", wb_adr_o, 32'h8);
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    expect_stream(32'h100, 3);
    @(negedge clk);
    redirect_i = 1'b0;
    check("t3_flush_valid", {31'd0, instr_valid_o}, 32'd0);
    cyc = 0;
    while (!wb_ack_i && cyc < 60) begin
      check("t3_hold_stb", {31'd0, wb_stb_o}, 32'd1);
      check("t3_hold_adr", wb_adr_o, 32'h8);
      @(negedge clk);
      cyc++;
    end
    check("t3_ack_seen", {31'd0, wb_ack_i}, 32'd1);
    @(negedge clk);
    check("t3_dropped", {31'd0, instr_valid_o}, 32'd0);
    wait_stb(5, "t3_new_stb");
    check("t3_new_adr", wb_adr_o, 32'h100);
    consume(3, 0, "t3");

    // redirect coinciding with ack and pop, two entries buffered
    sl_lat = 3; sl_base = 32'h200;
    do_reset();
    acks = 0; cyc = 0;
    while (acks < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (wb_ack_i) acks++;
    end
    check("t4_acks", acks, 3);
    check("t4_valid", {31'd0, instr_valid_o}, 32'd1);
    redirect_i = 1'b1; redirect_pc_i = 32'h103; instr_ready_i = 1'b1;
    expect_stream(32'h100, 2);
    @(negedge clk);
    redirect_i = 1'b0; instr_ready_i = 1'b0;
    check("t4_flushed", {31'd0, instr_valid_o}, 32'd0);
    wait_stb(5, "t4_stb");
    check("t4_adr", wb_adr_o, 32'h100);
    consume(2, 0, "t4");

    // ack and pop together with three entries buffered
    sl_lat = 3; sl_base = 32'h300;
    do_reset();
    expect_stream(32'h0, 8);
    acks = 0; cyc = 0;
    while (acks < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (wb_ack_i) acks++;
    end
    check("t5_acks", acks, 4);
    instr_ready_i = 1'b1;
    e = sb.pop_front();
    check("t5_pop_pc", instr_pc_o, e.pc);
    check("t5_pop_instr", instr_o, e.ins);
    @(negedge clk);
    instr_ready_i = 1'b0;
    wait_stb(3, "t5_still_room");
    check("t5_adr", wb_adr_o, 32'h10);
    consume(7, 1, "t5");

    // table of redirect scenarios
    for (int v = 0; v < 5; v++) begin
      sl_lat = vecs[v].lat;
      sl_base = vecs[v].base;
      redirect_i = 1'b1;
      redirect_pc_i = vecs[v].target;
      expect_stream(vecs[v].exp_first_pc, vecs[v].n);
      @(negedge clk);
      redirect_i = 1'b0;
      check($sformatf("vec%0d_flush", v), {31'd0, instr_valid_o}, 32'd0);
      consume(vecs[v].n, vecs[v].mode, $sformatf("vec%0d", v));
    end

    // slave that never acks
    sl_lat = 2; sl_base = 32'h400; sl_mute = 1'b1;
    do_reset();
    wait_stb(5, "na_stb");
`ifdef IFETCH_TIMEOUT_EN
    hi = 0;
    while (wb_stb_o && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    check("to_stb_cycles", hi, 16);
    check("to_err_set", {31'd0, fetch_err_o}, 32'd1);
    bad = 0;
    repeat (10) begin
      if (wb_stb_o) bad++;
      @(negedge clk);
    end
    check("to_no_req", bad, 0);
    sl_mute = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    expect_stream(32'h40, 2);
    @(negedge clk);
    redirect_i = 1'b0;
    check("to_err_clear", {31'd0, fetch_err_o}, 32'd0);
    wait_stb(5, "to_restart_stb");
    check("to_restart_adr", wb_adr_o, 32'h40);
    consume(2, 0, "to");
`else
    hi = 0;
    repeat (40) @(negedge clk);
    check("na_stb_held", {31'd0, wb_stb_o}, 32'd1);
    check("na_adr_held", wb_adr_o, 32'h0);
    check("na_err", {31'd0, fetch_err_o}, 32'd0);
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    expect_stream(32'h40, 2);
    @(negedge clk);
    redirect_i = 1'b0;
    sl_mute = 1'b0;
    wait_ack(20, "na_ack");
    @(negedge clk);
    wait_stb(5, "na_restart_stb");
    check("na_restart_adr", wb_adr_o, 32'h40);
    consume(2, 0, "na");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/wb_ifetch.md
Name: wb_ifetch

Overview:
Instruction fetch unit: a Wishbone classic read master feeding the core's decode stage from the SPI-flash instruction memory slave.
- Generates sequential word addresses from an internal fetch PC.
- Runs single-outstanding Wishbone reads and buffers returned words with their PC in a small prefetch FIFO.
- Presents a valid/ready instruction stream downstream.
- Supports redirect (branch/jump/trap) that flushes the buffer and restarts fetch.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset (word aligned)
DEPTH, 4, prefetch FIFO entries; power of two, >= 2
TIMEOUT, 255, bus watchdog limit in clk cycles (used only with IFETCH_TIMEOUT_EN)

Ports:
clk  in  1  clock, posedge
rst_n  in  1  asynchronous active-low reset
redirect_i  in  1  flush and restart fetch at redirect_pc_i
redirect_pc_i  in  32  new fetch address; bits [1:0] ignored
instr_valid_o  out  1  head FIFO entry valid
instr_ready_i  in  1  consumer accepts head entry
instr_o  out  32  head instruction word
instr_pc_o  out  32  address of head instruction
fetch_err_o  out  1  sticky bus-timeout flag
wb_adr_o  out  32  Wishbone address
wb_dat_o  out  32  tied 32'd0
wb_we_o  out  1  tied 0
wb_sel_o  out  4  tied 4'hF
wb_stb_o  out  1  strobe
wb_cyc_o  out  1  cycle
wb_ack_i  in  1  acknowledge
wb_dat_i  in  32  read data, sampled only when wb_ack_i=1

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; FIFO empty (rd/wr pointers 0, count 0); state S_IDLE.
  - wb_stb_o=wb_cyc_o=0; instr_valid_o=0; fetch_err_o=0.
- Outputs:
  - wb_stb_o/wb_cyc_o are registered and always equal each other.
  - wb_adr_o={fetch_pc[31:2],2'b00}.
- Handshake: pop when instr_valid_o & instr_ready_i.
  - instr_valid_o=(count!=0).
  - instr_o/instr_pc_o show the head entry combinationally; they are don't-care while invalid.
- S_IDLE:
  - If !redirect_i, count<DEPTH and fetch_err_o=0, assert stb/cyc next cycle and go to S_REQ.
  - Ack-return push may not overflow; one outstanding read max.
- S_REQ:
  - Hold stb/cyc and wb_adr_o stable until wb_ack_i.
  - On ack: push {fetch_pc, wb_dat_i}; fetch_pc+=4 (wraps mod 2^32); deassert stb/cyc; go to S_IDLE.
  - Stb/cyc stay low at least one cycle between transfers.
- S_DISCARD:
  - Entered on redirect while S_REQ and no ack that cycle.
  - Keep stb/cyc and the old address asserted until ack; drop the data; deassert; go to S_IDLE.
- Redirect (any state):
  - Flush FIFO (count=0, pointers 0); fetch_pc={redirect_pc_i[31:2],2'b00}; clear fetch_err_o.
  - instr_valid_o=0 in the following cycle.
  - Redirect wins over a same-cycle pop and over a same-cycle ack; acked data is dropped and the state goes to S_IDLE.
  - Redirect in S_DISCARD updates the target again.
- Simultaneous push and pop: count unchanged; pointers both advance (mod DEPTH).
- Full (count=DEPTH): no new request until a pop.
- Latency: with zero-wait ack, first instr_valid_o is 2 cycles after the first stb; throughput is one word per 3 cycles minimum.

Optional Feature:
IFETCH_TIMEOUT_EN
- Defined:
  - A cycle counter runs in S_REQ/S_DISCARD and resets on each new request.
  - When it reaches TIMEOUT with no ack: drop stb/cyc, set fetch_err_o=1 (sticky), go to S_IDLE, push nothing.
  - No further requests until redirect_i, which clears fetch_err_o.
- Undefined: no counter; fetch_err_o tied 0; cycles wait for ack indefinitely.

Test Plan:
- Reset, RESET_PC=0, slave acks after 66 cycles with 32'h0000_0013, ready=1 -> wb_adr_o=0; instr_valid_o pulses with instr_o=32'h13, instr_pc_o=0; next wb_adr_o=4 after ≥1 idle stb cycle.
- instr_ready_i=0, 4 acks with data 1,2,3,4 -> count=4, stb stays 0. Assert ready for one cycle -> pops data 1 (pc 0), then a request to 0x10 is issued.
- Redirect to 0x100 while a read of 0x8 is outstanding -> stb/cyc held with adr 0x8 until ack; data dropped; instr_valid_o=0; next request adr=0x100; first popped instr_pc_o=0x100.
- Redirect_pc 0x103 in the same cycle as ack and pop with FIFO holding 2 entries -> FIFO empty, acked word discarded, next adr=0x100.
- FIFO at 3 entries, ack and pop in the same cycle -> count stays 3; order of instr_pc_o strictly +4 sequential.
- IFETCH_TIMEOUT_EN, TIMEOUT=16, slave never acks -> stb/cyc drop after 16 cycles; fetch_err_o=1; no new stb. Redirect to 0x40 -> fetch_err_o=0, request adr=0x40.
